// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, and releases the
// core reset request only after a sustained lock. Lock losses re-sequence the PLL.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 100000,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [1:0] state_o,
    output logic [7:0] lock_loss_count,
    output logic [7:0] timeout_count
);

    localparam int MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYCLES = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [7:0]       timeout_count_n;
    logic [7:0]       lock_loss_count_n;
    logic             lk_meta;
    logic             lk;

    // pll_locked comes from the PLL's own output domain; only lk is used below.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RESET_PLL;
            cnt             <= '0;
            timeout_count   <= 8'd0;
            lock_loss_count <= 8'd0;
            pll_rst         <= 1'b1;
            core_rst        <= 1'b1;
            ready           <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            timeout_count   <= timeout_count_n;
            lock_loss_count <= lock_loss_count_n;
            pll_rst         <= (state_n == RESET_PLL);
            core_rst        <= (state_n != RUN);
            ready           <= (state_n == RUN);
        end
    end

    // The soft request overrides everything; a lock seen on the timeout cycle wins.
    always_comb begin
        state_n           = state;
        cnt_n             = cnt + CNT_W'(1);
        timeout_count_n   = timeout_count;
        lock_loss_count_n = lock_loss_count;
        if (soft_rst_req) begin
            state_n = RESET_PLL;
            cnt_n   = '0;
        end else begin
            unique case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                    end else if (cnt == WAIT_LAST) begin
                        state_n = RESET_PLL;
                        cnt_n   = '0;
                        if (timeout_count != 8'hFF) begin
                            timeout_count_n = timeout_count + 8'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    cnt_n = '0;
                    if (!lk) begin
                        state_n = RESET_PLL;
                        if (lock_loss_count != 8'hFF) begin
                            lock_loss_count_n = lock_loss_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios with
// spec-derived expectations, then random lock patterns against a timestamp model.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LTO = 20;
    localparam int LSC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic [1:0] state_o;
    logic [7:0] lock_loss_count;
    logic [7:0] timeout_count;

    int total = 0;
    int bad   = 0;

    // Reference model: phase plus the edge number at which it was entered.
    int m_cyc   = 0;
    int m_phase = 0;
    int m_enter = 0;
    int m_tc    = 0;
    int m_lc    = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES    (PRC),
        .LOCK_TIMEOUT      (LTO),
        .LOCK_STABLE_CYCLES(LSC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_rst_req   (soft_rst_req),
        .pll_rst        (pll_rst),
        .core_rst       (core_rst),
        .ready          (ready),
        .state_o        (state_o),
        .lock_loss_count(lock_loss_count),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model phases: 0 reset pulse, 1 waiting for lock, 2 qualifying, 3 running.
    task automatic model_edge();
        bit lk_seen;
        m_cyc++;
        lk_seen = m_s2;
        if (rst) begin
            m_phase = 0; m_enter = m_cyc; m_tc = 0; m_lc = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = pll_locked;
            if (soft_rst_req) begin
                m_phase = 0; m_enter = m_cyc;
            end else if (m_phase == 0) begin
                if (m_cyc - m_enter == PRC) begin m_phase = 1; m_enter = m_cyc; end
            end else if (m_phase == 1) begin
                if (lk_seen) begin
                    m_phase = 2; m_enter = m_cyc;
                end else if (m_cyc - m_enter == LTO) begin
                    m_phase = 0; m_enter = m_cyc; m_tc = (m_tc < 255) ? m_tc + 1 : 255;
                end
            end else if (m_phase == 2) begin
                if (!lk_seen) begin
                    m_phase = 1; m_enter = m_cyc;
                end else if (m_cyc - m_enter == LSC) begin
                    m_phase = 3; m_enter = m_cyc;
                end
            end else begin
                if (!lk_seen) begin
                    m_phase = 0; m_enter = m_cyc; m_lc = (m_lc < 255) ? m_lc + 1 : 255;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_for_state(input logic [1:0] target, input int budget);
        int n;
        n = 0;
        while (state_o !== target && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
        repeat (3) step();
        total += 6;
        if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
        if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_pll_rst: got %b want 1", pll_rst); end
        if (core_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_core_rst: got %b want 1", core_rst); end
        if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        if (timeout_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_tc: got %0d want 0", timeout_count); end
        if (lock_loss_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_lc: got %0d want 0", lock_loss_count); end
        rst = 1'b0;
    endtask

    task automatic test_bringup();
        int n;
        int k;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (pll_rst !== 1'b1) break;
            n++;
            step();
        end
        total++;
        if (n != PRC) begin bad++; $display("[TB] FAIL bringup_pll_rst_len: got %0d want %0d", n, PRC); end
        repeat (5) step();
        pll_locked = 1'b1;
        k = 0;
        while (ready !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        total += 5;
        if (k != 2 + 1 + LSC) begin bad++; $display("[TB] FAIL bringup_latency: got %0d want %0d", k, 2 + 1 + LSC); end
        if (core_rst !== 1'b0) begin bad++; $display("[TB] FAIL bringup_core_rst: got %b want 0", core_rst); end
        if (state_o !== 2'd3) begin bad++; $display("[TB] FAIL bringup_state: got %0d want 3", state_o); end
        if (timeout_count !== 8'd0) begin bad++; $display("[TB] FAIL bringup_tc: got %0d want 0", timeout_count); end
        if (lock_loss_count !== 8'd0) begin bad++; $display("[TB] FAIL bringup_lc: got %0d want 0", lock_loss_count); end
    endtask

    task automatic test_timeout();
        int rises;
        int last_rise;
        logic prev;
        rst = 1'b1; pll_locked = 1'b0;
        step();
        rst = 1'b0;
        rises = 0; last_rise = -1; prev = pll_rst;
        for (int i = 0; i < 80; i++) begin
            step();
            if (pll_rst === 1'b1 && prev === 1'b0) begin
                rises++;
                total++;
                if (timeout_count !== 8'(rises)) begin
                    bad++; $display("[TB] FAIL timeout_count_step: got %0d want %0d", timeout_count, rises);
                end
                if (last_rise >= 0) begin
                    total++;
                    if (m_cyc - last_rise != PRC + LTO) begin
                        bad++; $display("[TB] FAIL timeout_period: got %0d want %0d", m_cyc - last_rise, PRC + LTO);
                    end
                end
                last_rise = m_cyc;
            end
            prev = pll_rst;
        end
        total++;
        if (rises != 3) begin bad++; $display("[TB] FAIL timeout_rises: got %0d want 3", rises); end
        for (int i = 0; i < 300 * (PRC + LTO); i++) step();
        total++;
        if (timeout_count !== 8'd255) begin bad++; $display("[TB] FAIL timeout_saturate: got %0d want 255", timeout_count); end
    endtask

    task automatic test_glitch();
        bit seen_wait;
        bit back_stable;
        int k;
        rst = 1'b1;
        step();
        rst = 1'b0; pll_locked = 1'b1;
        wait_for_state(2'd2, 40);
        total++;
        if (state_o !== 2'd2) begin bad++; $display("[TB] FAIL glitch_reach_stable: got %0d want 2", state_o); end
        repeat (3) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        seen_wait = 1'b0; back_stable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state_o === 2'd1) seen_wait = 1'b1;
            if (seen_wait && state_o === 2'd2) begin back_stable = 1'b1; break; end
        end
        total += 2;
        if (!seen_wait) begin bad++; $display("[TB] FAIL glitch_to_wait: got 0 want 1"); end
        if (!back_stable) begin bad++; $display("[TB] FAIL glitch_back_stable: got %0d want 2", state_o); end
        k = 0;
        while (ready !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        total += 2;
        if (k != LSC) begin bad++; $display("[TB] FAIL glitch_requalify: got %0d want %0d", k, LSC); end
        if (lock_loss_count !== 8'd0) begin bad++; $display("[TB] FAIL glitch_lc: got %0d want 0", lock_loss_count); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            total++;
            if (ready !== 1'b1 || core_rst !== 1'b0) begin
                bad++; $display("[TB] FAIL loss_early_%0d: ready=%b core_rst=%b want 1/0", i, ready, core_rst);
            end
        end
        step();
        total += 4;
        if (core_rst !== 1'b1) begin bad++; $display("[TB] FAIL loss_core_rst: got %b want 1", core_rst); end
        if (ready !== 1'b0) begin bad++; $display("[TB] FAIL loss_ready: got %b want 0", ready); end
        if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL loss_state: got %0d want 0", state_o); end
        if (lock_loss_count !== 8'd1) begin bad++; $display("[TB] FAIL loss_count: got %0d want 1", lock_loss_count); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (pll_rst !== 1'b1) break;
            n++;
            step();
        end
        total++;
        if (n != PRC) begin bad++; $display("[TB] FAIL loss_pll_rst_len: got %0d want %0d", n, PRC); end
        pll_locked = 1'b1;
        wait_for_state(2'd3, 60);
        total += 2;
        if (ready !== 1'b1) begin bad++; $display("[TB] FAIL loss_relock: got %b want 1", ready); end
        if (lock_loss_count !== 8'd1) begin bad++; $display("[TB] FAIL loss_count_hold: got %0d want 1", lock_loss_count); end
    endtask

    task automatic test_soft_req();
        int n;
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        total += 3;
        if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL soft_run_state: got %0d want 0", state_o); end
        if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL soft_run_pll_rst: got %b want 1", pll_rst); end
        if (lock_loss_count !== 8'd1 || timeout_count !== 8'd0) begin
            bad++; $display("[TB] FAIL soft_run_counts: lc=%0d tc=%0d want 1/0", lock_loss_count, timeout_count);
        end
        repeat (2) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        total++;
        if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL soft_reset_state: got %0d want 0", state_o); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (pll_rst !== 1'b1) break;
            n++;
            step();
        end
        total += 2;
        if (n != PRC) begin bad++; $display("[TB] FAIL soft_restart_len: got %0d want %0d", n, PRC); end
        if (lock_loss_count !== 8'd1 || timeout_count !== 8'd0) begin
            bad++; $display("[TB] FAIL soft_reset_counts: lc=%0d tc=%0d want 1/0", lock_loss_count, timeout_count);
        end
    endtask

    task automatic test_rst_in_run();
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (timeout_count !== 8'd1 && n < 80) begin
            step();
            n++;
        end
        pll_locked = 1'b1;
        wait_for_state(2'd3, 80);
        total++;
        if (state_o !== 2'd3 || timeout_count !== 8'd1 || lock_loss_count !== 8'd1) begin
            bad++; $display("[TB] FAIL rstrun_setup: state=%0d tc=%0d lc=%0d want 3/1/1", state_o, timeout_count, lock_loss_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 6;
        if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL rstrun_state: got %0d want 0", state_o); end
        if (pll_rst !== 1'b1) begin bad++; $display("[TB] FAIL rstrun_pll_rst: got %b want 1", pll_rst); end
        if (core_rst !== 1'b1) begin bad++; $display("[TB] FAIL rstrun_core_rst: got %b want 1", core_rst); end
        if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rstrun_ready: got %b want 0", ready); end
        if (timeout_count !== 8'd0) begin bad++; $display("[TB] FAIL rstrun_tc: got %0d want 0", timeout_count); end
        if (lock_loss_count !== 8'd0) begin bad++; $display("[TB] FAIL rstrun_lc: got %0d want 0", lock_loss_count); end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pll_locked = ~pll_locked;
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 60));
            end
            hold--;
            soft_rst_req = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step();
            total += 6;
            if (state_o !== 2'(m_phase)) begin bad++; $display("[TB] FAIL rand_state @%0d: got %0d want %0d", i, state_o, m_phase); end
            if (pll_rst !== (m_phase == 0)) begin bad++; $display("[TB] FAIL rand_pll_rst @%0d: got %b want %b", i, pll_rst, m_phase == 0); end
            if (core_rst !== (m_phase != 3)) begin bad++; $display("[TB] FAIL rand_core_rst @%0d: got %b want %b", i, core_rst, m_phase != 3); end
            if (ready !== (m_phase == 3)) begin bad++; $display("[TB] FAIL rand_ready @%0d: got %b want %b", i, ready, m_phase == 3); end
            if (timeout_count !== 8'(m_tc)) begin bad++; $display("[TB] FAIL rand_tc @%0d: got %0d want %0d", i, timeout_count, m_tc); end
            if (lock_loss_count !== 8'(m_lc)) begin bad++; $display("[TB] FAIL rand_lc @%0d: got %0d want %0d", i, lock_loss_count, m_lc); end
        end
        soft_rst_req = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_soft_req();
        test_rst_in_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
